// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite word-organised SRAM slave with programmable wait states and
// two-cycle ERROR responses for misaligned, oversized or out-of-range transfers.
module ahb3lite_sram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HWORD   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(4 * MEM_WORDS);
    localparam logic [2:0] WAIT_LAST = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t           state, next_state;
    logic [2:0]       wait_cnt, next_cnt;
    logic [IDX_W+1:0] addr_q;
    logic             write_q;
    logic [2:0]       size_q;
    logic [31:0]      mem [MEM_WORDS];

    logic             trans_active, slave_ready, accept, cap_err;
    logic [3:0]       byte_en;
    logic [IDX_W-1:0] word_idx;
    logic             unused_ok;

    assign unused_ok    = ^{HBURST, HPROT};
    assign trans_active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign slave_ready  = (state != S_WAIT) && (state != S_ERR1);
    assign accept       = HSEL && HREADY && trans_active && slave_ready;

    assign cap_err = (HSIZE > HSIZE_WORD)
                  || ((HSIZE == HSIZE_HWORD) && HADDR[0])
                  || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00))
                  || ({1'b0, HADDR} >= MEM_BYTES);

    assign HREADYOUT = slave_ready;
    assign HRESP     = (state == S_ERR1) || (state == S_ERR2);

    always_comb begin
        next_state = state;
        next_cnt   = wait_cnt;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                next_state = S_IDLE;
                if (accept) begin
                    next_cnt = 3'd0;
                    if (cap_err)              next_state = S_ERR1;
                    else if (WAIT_STATES > 0) next_state = S_WAIT;
                    else                      next_state = S_DATA;
                end
            end
            S_WAIT: begin
                next_cnt = wait_cnt + 3'd1;
                if (wait_cnt == WAIT_LAST) next_state = S_DATA;
            end
            S_ERR1:  next_state = S_ERR2;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
            if (accept) begin
                addr_q  <= HADDR[IDX_W+1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
        end
    end

    // Error transfers never reach DATA, so addr_q is always in range here.
    assign word_idx = addr_q[IDX_W+1:2];

    always_comb begin
        byte_en = 4'b1111;
        case (size_q)
            HSIZE_BYTE:  byte_en = 4'b0001 << addr_q[1:0];
            HSIZE_HWORD: byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default:     byte_en = 4'b1111;
        endcase
    end

    // Reset forces the state to IDLE asynchronously, which drops any pending write.
    always_ff @(posedge HCLK) begin
        if ((state == S_DATA) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HRDATA = ((state == S_DATA) && !write_q) ? mem[word_idx] : 32'd0;
endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench: one slave with one wait state, one with zero wait states,
// sharing the request bus; use0 steers HSEL and the observed outputs.
module tb_ahb3lite_sram_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        hsel, use0;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;

    logic [31:0] hrdata1, hrdata0;
    logic        rdy1, rdy0, resp1, resp0;

    wire [31:0] hrdata = use0 ? hrdata0 : hrdata1;
    wire        rdy    = use0 ? rdy0 : rdy1;
    wire        resp   = use0 ? resp0 : resp1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ahb3lite_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(1), .ADDR_WIDTH(16)) dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel && !use0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(rdy1), .HRDATA(hrdata1), .HREADYOUT(rdy1), .HRESP(resp1)
    );

    ahb3lite_sram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0), .ADDR_WIDTH(16)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel && use0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADY(rdy0), .HRDATA(hrdata0), .HREADYOUT(rdy0), .HRESP(resp0)
    );

    localparam int NP = 14;
    logic [1:0]  p_tr    [NP] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b01,
                                  2'b11, 2'b00, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
    logic        p_wr    [NP] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] p_ad    [NP] = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h0, 16'h4, 16'h8,
                                  16'h8, 16'hC, 16'hC, 16'h0, 16'h0, 16'h4, 16'h4};
    logic [31:0] p_wd    [NP] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3,
                                  32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0,
                                  32'hFFFFFFFF, 32'h0, 32'h55AA55AA, 32'h0};
    logic [31:0] p_rexp  [NP] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA0A0A0A0, 32'hB1B1B1B1,
                                  32'h0, 32'hC2C2C2C2, 32'h0, 32'hD3D3D3D3, 32'h0,
                                  32'hA0A0A0A0, 32'h0, 32'h55AA55AA};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Single transfer, entered and left at posedge+1 with the bus idle.
    task automatic xfer(input string tag, input logic wr, input logic [15:0] a,
                        input logic [2:0] sz, input logic [31:0] wd,
                        input logic [31:0] rexp, input logic err, input int ws);
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = ~wd;
        if (err) begin
            @(negedge clk);
            chk({tag, "_err1"}, {30'd0, rdy, resp}, 32'd1);
            chk({tag, "_err1_rdata"}, hrdata, 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, "_err2"}, {30'd0, rdy, resp}, 32'd3);
            @(posedge clk); #1;
        end else begin
            for (int i = 0; i < ws; i++) begin
                @(negedge clk);
                chk({tag, "_wait"}, {30'd0, rdy, resp}, 32'd0);
                chk({tag, "_wait_rdata"}, hrdata, 32'd0);
                @(posedge clk); #1;
            end
            hwdata = wd;
            @(negedge clk);
            chk({tag, "_data"}, {30'd0, rdy, resp}, 32'd2);
            chk({tag, "_rdata"}, hrdata, wr ? 32'd0 : rexp);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; use0 = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011; hwdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'd0, rdy}, 32'd1);
        chk("reset_resp", {31'd0, resp}, 32'd0);
        chk("reset_rdata", hrdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        xfer("w10",   1'b1, 16'h0010, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0, 1);
        xfer("r10",   1'b0, 16'h0010, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, 1);
        xfer("wb12",  1'b1, 16'h0012, 3'b000, 32'h00AA0000, 32'h0,        1'b0, 1);
        xfer("r10b",  1'b0, 16'h0010, 3'b010, 32'h0,        32'hDEAABEEF, 1'b0, 1);
        xfer("w00",   1'b1, 16'h0000, 3'b010, 32'h11111111, 32'h0,        1'b0, 1);
        xfer("emis",  1'b1, 16'h0002, 3'b010, 32'hFFFFFFFF, 32'h0,        1'b1, 1);
        xfer("eoor",  1'b1, 16'h1000, 3'b010, 32'hFFFFFFFF, 32'h0,        1'b1, 1);
        xfer("ehw",   1'b1, 16'h0011, 3'b001, 32'hFFFFFFFF, 32'h0,        1'b1, 1);
        xfer("esize", 1'b0, 16'h0000, 3'b011, 32'h0,        32'h0,        1'b1, 1);
        xfer("r00",   1'b0, 16'h0000, 3'b010, 32'h0,        32'h11111111, 1'b0, 1);
        xfer("r10c",  1'b0, 16'h0010, 3'b010, 32'h0,        32'hDEAABEEF, 1'b0, 1);
        xfer("wh12",  1'b1, 16'h0012, 3'b001, 32'h12340000, 32'h0,        1'b0, 1);
        xfer("r10d",  1'b0, 16'h0010, 3'b010, 32'h0,        32'h1234BEEF, 1'b0, 1);
        xfer("w20",   1'b1, 16'h0020, 3'b010, 32'h12345678, 32'h0,        1'b0, 1);

        // Reset asserted during the wait state of a write to 0x20.
        hsel = 1'b1; htrans = 2'b10; haddr = 16'h0020; hwrite = 1'b1; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rstmid_wait", {30'd0, rdy, resp}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rstmid_ready", {31'd0, rdy}, 32'd1);
        chk("rstmid_resp", {31'd0, resp}, 32'd0);
        chk("rstmid_rdata", hrdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer("r20",   1'b0, 16'h0020, 3'b010, 32'h0,        32'h12345678, 1'b0, 1);

        // Zero-wait pipelined burst with BUSY/IDLE beats on the second slave.
        use0 = 1'b1;
        for (int i = 0; i <= NP; i++) begin
            if (i < NP) begin
                hsel = 1'b1; htrans = p_tr[i]; haddr = p_ad[i]; hwrite = p_wr[i]; hsize = 3'b010;
            end else begin
                hsel = 1'b0; htrans = 2'b00;
            end
            if (i > 0) hwdata = p_wd[i-1];
            @(negedge clk);
            chk($sformatf("pipe%0d_rdy_resp", i), {30'd0, rdy, resp}, 32'd2);
            chk($sformatf("pipe%0d_rdata", i), hrdata, (i > 0) ? p_rexp[i-1] : 32'd0);
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ahb3lite_sram_slave.md
Name: ahb3lite_sram_slave

Overview:
AHB3-Lite word-organised SRAM slave with programmable wait states and ERROR response generation. It sits directly downstream of the AHB master/interconnect and is the slave-side device whose HREADYOUT/HRESP/HRDATA behaviour the slave-side formal property set checks. It uses the shared ahb3lite package encodings (HTRANS_*, HSIZE_*, HBURST_*).

Parameters:
MEM_WORDS, 1024, number of 32-bit words; valid byte address range 0 .. 4*MEM_WORDS-1
WAIT_STATES, 1, HREADYOUT-low cycles inserted in each OKAY data phase of NONSEQ/SEQ transfers (0..7)
ADDR_WIDTH, 16, HADDR width

Ports:
HCLK  in  1  clock; all state updates on its rising edge
HRESET  in  1  reset
HSEL  in  1  slave select
HADDR  in  ADDR_WIDTH  byte address
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
HWRITE  in  1  1=write
HSIZE  in  3  transfer size
HBURST  in  3  burst type; accepted but not used
HPROT  in  4  protection; ignored
HWDATA  in  32  write data, valid in the data phase
HREADY  in  1  bus ready, the combined HREADYOUT of all slaves
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (HRESET=1, async): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, latched address-phase registers cleared, wait counter=0. Memory contents are not cleared. Reset mid-transfer abandons the transfer and any pending write is not committed.
- Address-phase capture at a rising edge when HSEL & HREADY & HTRANS[1]=1 (NONSEQ/SEQ): latch HADDR, HWRITE, HSIZE.
- IDLE/BUSY with HSEL & HREADY: no capture; the next cycle is zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Error check at capture. The transfer is an error if any of these holds:
  - HSIZE > HSIZE_WORD;
  - address is misaligned (HWORD with HADDR[0]=1, or WORD with HADDR[1:0]!=0);
  - HADDR >= 4*MEM_WORDS.
- State machine: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1. A valid capture goes to WAIT if WAIT_STATES>0, otherwise to DATA. An error capture goes to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. The counter counts WAIT_STATES cycles, then the state goes to DATA.
  - DATA: HREADYOUT=1, HRESP=0; the transfer completes at the end of this cycle. A new capture in the same cycle (pipelined) is handled as from IDLE; otherwise the state returns to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, lasting one cycle, then ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. A capture in the same cycle is handled as from IDLE; otherwise the state returns to IDLE.
- An error transfer never inserts wait states and never writes memory.
- HRESP=0 whenever the state is not ERR1/ERR2. HRESP=1 with HREADYOUT=1 is always preceded by exactly one cycle of HRESP=1 with HREADYOUT=0.
- Writes: committed at the edge that ends the DATA cycle, using little-endian byte lanes.
  - BYTE writes lane HADDR[1:0].
  - HWORD writes lanes {HADDR[1],0} and {HADDR[1],1}.
  - WORD writes all four lanes.
  - Unaddressed lanes are preserved.
- Reads: HRDATA = full 32-bit word mem[addr>>2] during the DATA cycle of a read, combinational from the array. At all other times HRDATA=0. The master extracts the byte/halfword lanes.
- Read-after-write: a read whose DATA cycle immediately follows a write's DATA cycle to the same word returns the newly written data.
- HWDATA is sampled only in the DATA cycle; it may change during WAIT.
- HSEL=0 or HREADY=0 at an edge: no capture. An in-progress data phase still completes normally.

Test Plan:
- Reset, then WAIT_STATES=1: WORD write 0xDEADBEEF to 0x0010, then WORD read of 0x0010. Each transfer shows HREADYOUT low for 1 cycle then high with HRESP=0. The read DATA cycle shows HRDATA=0xDEADBEEF.
- BYTE write 0xAA on lane 2 to 0x0012 over the existing 0xDEADBEEF, then read 0x0010 -> HRDATA=0xDEAABEEF.
- WORD access to 0x0002 (misaligned) and to 0x1000 with MEM_WORDS=1024 (out of range):
  - each shows HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1;
  - memory is unchanged;
  - the next transfer returns OKAY.
- WAIT_STATES=0, back-to-back pipelined NONSEQ/SEQ writes to 0x0,0x4,0x8,0xC then reads -> HREADYOUT stays 1 throughout and the reads return the four written words in order.
- IDLE and BUSY cycles with HSEL=1 interleaved in a burst -> HREADYOUT=1, HRESP=0, no memory change.
- HRESET asserted in the WAIT cycle of a write to 0x0020 -> outputs immediately reach their reset values and mem[8] keeps its previous value.
